// File: rtl/pipe_pkg.sv
// Shared encodings and constants for the pipeline stall/flush/exception sequencer.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        INT_WAIT = 2'd1,
        IN_HDL   = 2'd2
    } pc_state_e;

    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] RESET_PC   = 32'h0000_3000;

    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;
    localparam int unsigned CNT_W_DEF    = 4;

    // True when an enabled source register matches a real (non-$0) destination.
    function automatic logic reg_hit(input logic en, input logic [4:0] src,
                                     input logic [4:0] dst);
        return en && (dst != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// HI/LO unit occupancy counter: loaded on mult/div issue, counts down to idle.
module md_busy_ctr
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic md_busy_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A new issue always reloads, so the most recent op defines occupancy.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign md_busy_c = (cnt_q != '0) | start;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush/exception sequencer for the 5-stage pipeline: hazards, HI/LO
// occupancy, interrupt entry and eret redirect.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic       use_rs_D,
    input  logic       use_rt_D,
    input  logic       br_D,
    input  logic       md_use_D,
    input  logic       eret_D,
    input  logic [4:0] wreg_E,
    input  logic       load_E,
    input  logic       md_start_E,
    input  logic       md_div_E,
    input  logic [4:0] wreg_M,
    input  logic       load_M,
    input  logic       valid_M,
    input  logic       irq,
    output logic       en_pc,
    output logic       en_ifid,
    output logic       flush_idex,
    output logic       IntReq,
    output logic       eret
);

    pc_state_e state_q;
    pc_state_e state_d;

    logic hit_e;
    logic hit_m;
    logic hz_ld;
    logic hz_br;
    logic hz_md;
    logic md_busy;
    logic stall;
    logic int_take;
    logic eret_take;

    md_busy_ctr #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md (
        .clk       (clk),
        .reset     (reset),
        .start     (md_start_E),
        .is_div    (md_div_E),
        .md_busy_c (md_busy)
    );

    assign hit_e = reg_hit(use_rs_D, rs_D, wreg_E) | reg_hit(use_rt_D, rt_D, wreg_E);
    assign hit_m = reg_hit(use_rs_D, rs_D, wreg_M) | reg_hit(use_rt_D, rt_D, wreg_M);

    // Branches compare in D, so any E producer and an M load are both too late.
    assign hz_ld = load_E & hit_e;
    assign hz_br = br_D & (hit_e | (load_M & hit_m));
    assign hz_md = md_use_D & md_busy;
    assign stall = hz_ld | hz_br | hz_md;

    // Interrupt entry needs a real instruction in M so EPC has something to capture.
    assign int_take  = irq & valid_M & (state_q != IN_HDL);
    assign eret_take = eret_D & ~stall;

    always_comb begin
        state_d    = state_q;
        en_pc      = 1'b1;
        en_ifid    = 1'b1;
        flush_idex = 1'b0;
        IntReq     = 1'b0;
        eret       = 1'b0;
        if (reset) begin
            state_d = RUN;
        end else if (int_take) begin
            IntReq     = 1'b1;
            flush_idex = 1'b1;
            state_d    = IN_HDL;
        end else begin
            if (eret_take) begin
                eret       = 1'b1;
                flush_idex = 1'b1;
            end else if (stall) begin
                en_pc      = 1'b0;
                en_ifid    = 1'b0;
                flush_idex = 1'b1;
            end
            unique case (state_q)
                RUN:      if (irq) state_d = INT_WAIT;
                INT_WAIT: if (!irq) state_d = RUN;
                IN_HDL:   if (eret_take) state_d = RUN;
                default:  state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scenario bench for pipe_ctrl: expected output vectors are queued as stimulus
// is applied and compared against sampled outputs at the end of each scenario.
module tb_pipe_ctrl;

    // {en_pc, en_ifid, flush_idex, IntReq, eret}
    localparam logic [4:0] NORM  = 5'b11000;
    localparam logic [4:0] STALL = 5'b00100;
    localparam logic [4:0] INTR  = 5'b11110;
    localparam logic [4:0] ERET  = 5'b11101;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, wreg_E, wreg_M;
    logic       use_rs_D, use_rt_D, br_D, md_use_D, eret_D;
    logic       load_E, md_start_E, md_div_E, load_M, valid_M, irq;
    logic       en_pc, en_ifid, flush_idex, IntReq, eret;

    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .use_rs_D   (use_rs_D),
        .use_rt_D   (use_rt_D),
        .br_D       (br_D),
        .md_use_D   (md_use_D),
        .eret_D     (eret_D),
        .wreg_E     (wreg_E),
        .load_E     (load_E),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .wreg_M     (wreg_M),
        .load_M     (load_M),
        .valid_M    (valid_M),
        .irq        (irq),
        .en_pc      (en_pc),
        .en_ifid    (en_ifid),
        .flush_idex (flush_idex),
        .IntReq     (IntReq),
        .eret       (eret)
    );

    task automatic clr_in();
        rs_D = 5'd0; rt_D = 5'd0; use_rs_D = 1'b0; use_rt_D = 1'b0;
        br_D = 1'b0; md_use_D = 1'b0; eret_D = 1'b0;
        wreg_E = 5'd0; load_E = 1'b0; md_start_E = 1'b0; md_div_E = 1'b0;
        wreg_M = 5'd0; load_M = 1'b0; valid_M = 1'b0; irq = 1'b0;
    endtask

    // Queue the expected vector for the current inputs, sample mid-cycle, advance.
    task automatic step(input logic [4:0] e);
        exp_q.push_back(e);
        @(negedge clk);
        obs_q.push_back({en_pc, en_ifid, flush_idex, IntReq, eret});
        @(posedge clk);
        #1;
    endtask

    task automatic load_hazard_rs8();
        load_E = 1'b1; wreg_E = 5'd8; rs_D = 5'd8; use_rs_D = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load_hazard_rs8();
        irq = 1'b1; valid_M = 1'b1; eret_D = 1'b1; md_use_D = 1'b1; md_start_E = 1'b1;
        step(NORM);
        step(NORM);
        n_checks++;
        if (2'(dut.state_q) !== 2'd0)
            $display("FAIL reset_state got %0d exp 0", 2'(dut.state_q));
        else n_pass++;
        reset = 1'b0;
        clr_in();
        step(NORM);
        while (exp_q.size() > 0) begin
            logic [4:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL reset_outs got %b exp %b", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        load_hazard_rs8(); rt_D = 5'd1; use_rt_D = 1'b1;
        step(STALL);
        load_E = 1'b0; wreg_E = 5'd0; load_M = 1'b1; wreg_M = 5'd8; valid_M = 1'b1;
        step(NORM);
        clr_in(); load_E = 1'b1; wreg_E = 5'd0; rs_D = 5'd0; use_rs_D = 1'b1;
        step(NORM);
        clr_in(); load_E = 1'b1; wreg_E = 5'd12; rt_D = 5'd12; use_rt_D = 1'b1;
        step(STALL);
        use_rt_D = 1'b0;
        step(NORM);
        clr_in();
        while (exp_q.size() > 0) begin
            logic [4:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL load_use got %b exp %b", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_branch();
        br_D = 1'b1; rs_D = 5'd8; use_rs_D = 1'b1; load_E = 1'b1; wreg_E = 5'd8;
        step(STALL);
        load_E = 1'b0; wreg_E = 5'd0; load_M = 1'b1; wreg_M = 5'd8;
        step(STALL);
        load_M = 1'b0; wreg_M = 5'd0;
        step(NORM);
        wreg_E = 5'd8;
        step(STALL);
        wreg_E = 5'd0; wreg_M = 5'd8;
        step(NORM);
        clr_in();
        while (exp_q.size() > 0) begin
            logic [4:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL branch got %b exp %b", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_mdu();
        md_start_E = 1'b1; md_div_E = 1'b1;
        step(NORM);
        md_start_E = 1'b0; md_div_E = 1'b0; md_use_D = 1'b1;
        for (int i = 0; i < 10; i++) step(STALL);
        step(NORM);
        md_use_D = 1'b0; md_start_E = 1'b1;
        step(NORM);
        md_start_E = 1'b0; md_use_D = 1'b1;
        for (int i = 0; i < 5; i++) step(STALL);
        step(NORM);
        // later mult reloads over an in-flight div
        md_use_D = 1'b0; md_start_E = 1'b1; md_div_E = 1'b1;
        step(NORM);
        md_start_E = 1'b0; md_div_E = 1'b0;
        step(NORM);
        step(NORM);
        md_start_E = 1'b1;
        step(NORM);
        md_start_E = 1'b0; md_use_D = 1'b1;
        for (int i = 0; i < 5; i++) step(STALL);
        step(NORM);
        md_use_D = 1'b1; md_start_E = 1'b1;
        step(STALL);
        clr_in();
        for (int i = 0; i < 6; i++) step(NORM);
        while (exp_q.size() > 0) begin
            logic [4:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL mdu got %b exp %b", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_interrupt();
        irq = 1'b1; valid_M = 1'b0;
        step(NORM);
        n_checks++;
        if (2'(dut.state_q) !== 2'd1)
            $display("FAIL int_wait_state got %0d exp 1", 2'(dut.state_q));
        else n_pass++;
        step(NORM);
        load_hazard_rs8();
        step(STALL);
        valid_M = 1'b1;
        step(INTR);
        n_checks++;
        if (2'(dut.state_q) !== 2'd2)
            $display("FAIL in_hdl_state got %0d exp 2", 2'(dut.state_q));
        else n_pass++;
        clr_in(); irq = 1'b1; valid_M = 1'b1;
        step(NORM);
        irq = 1'b0;
        step(NORM);
        irq = 1'b1;
        step(NORM);
        clr_in();
        while (exp_q.size() > 0) begin
            logic [4:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL interrupt got %b exp %b", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_eret_hazard();
        eret_D = 1'b1; load_hazard_rs8();
        step(STALL);
        load_E = 1'b0; wreg_E = 5'd0;
        step(ERET);
        n_checks++;
        if (2'(dut.state_q) !== 2'd0)
            $display("FAIL eret_state got %0d exp 0", 2'(dut.state_q));
        else n_pass++;
        clr_in();
        step(NORM);
        irq = 1'b1; valid_M = 1'b0;
        step(NORM);
        irq = 1'b0; valid_M = 1'b1;
        step(NORM);
        n_checks++;
        if (2'(dut.state_q) !== 2'd0)
            $display("FAIL irq_drop_state got %0d exp 0", 2'(dut.state_q));
        else n_pass++;
        clr_in();
        while (exp_q.size() > 0) begin
            logic [4:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL eret_hazard got %b exp %b", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        irq = 1'b1; valid_M = 1'b1;
        step(INTR);
        clr_in(); md_start_E = 1'b1; md_div_E = 1'b1;
        step(NORM);
        clr_in();
        for (int i = 0; i < 3; i++) step(NORM);
        n_checks++;
        if (2'(dut.state_q) !== 2'd2)
            $display("FAIL pre_reset_state got %0d exp 2", 2'(dut.state_q));
        else n_pass++;
        reset = 1'b1; irq = 1'b1; valid_M = 1'b1; md_use_D = 1'b1; eret_D = 1'b1;
        load_hazard_rs8();
        step(NORM);
        reset = 1'b0; clr_in(); md_use_D = 1'b1;
        step(NORM);
        n_checks++;
        if (2'(dut.state_q) !== 2'd0)
            $display("FAIL post_reset_state got %0d exp 0", 2'(dut.state_q));
        else n_pass++;
        md_use_D = 1'b0; irq = 1'b1; valid_M = 1'b1;
        step(INTR);
        clr_in();
        step(NORM);
        while (exp_q.size() > 0) begin
            logic [4:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL reset_mid got %b exp %b", o, e);
            else n_pass++;
        end
    endtask

    initial begin
        clr_in();
        reset = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mdu();
        test_interrupt();
        test_eret_hazard();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
